// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter: N hosts share one device port, and responses are routed back in grant order.
// Latency: request to grant is combinational (0 cycles); the device response reaches its host in the same cycle.
// Backpressure: a stalled request holds its winner until granted; dev_req_o drops while the routing FIFO is full.
//
// Ports:
//   clk_i, rst_i                 clock and synchronous active-high reset
//   host_req_i / host_*_i        per-host request and payload (packed per host)
//   host_gnt_o, host_rvalid_o    per-host grant and response valid
//   host_rdata_o, host_err_o     response data and error, shared by all hosts
//   dev_*                        device-side request, grant and response
//   protocol_err_o               sticky: a response arrived with nothing outstanding

// Small synchronous FIFO. push is ignored when full and pop is ignored when empty.
module bus_rr_fifo #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdat_i,
  output logic [Width-1:0] rdat_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign rdat_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = wdat_i;
      wr_d        = ptr_inc(wr_q);
    end
    if (do_pop) rd_d = ptr_inc(rd_q);
    // Simultaneous push and pop leaves the occupancy unchanged.
    if (do_push && !do_pop) cnt_d = cnt_q + CntW'(1);
    if (!do_push && do_pop) cnt_d = cnt_q - CntW'(1);
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

module bus_rr_arbiter #(
  parameter int unsigned NrHosts        = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NrHosts-1:0]                  host_req_i,
  input  logic [NrHosts-1:0][AddrWidth-1:0]   host_addr_i,
  input  logic [NrHosts-1:0]                  host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0] host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]   host_wdata_i,
  output logic [NrHosts-1:0]                  host_gnt_o,
  output logic [NrHosts-1:0]                  host_rvalid_o,
  output logic [DataWidth-1:0]                host_rdata_o,
  output logic                                host_err_o,
  output logic                                dev_req_o,
  output logic [AddrWidth-1:0]                dev_addr_o,
  output logic                                dev_we_o,
  output logic [DataWidth/8-1:0]              dev_be_o,
  output logic [DataWidth-1:0]                dev_wdata_o,
  input  logic                                dev_gnt_i,
  input  logic                                dev_rvalid_i,
  input  logic [DataWidth-1:0]                dev_rdata_i,
  input  logic                                dev_err_i,
  output logic                                protocol_err_o
);
  localparam int unsigned IdxW = $clog2(NrHosts);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] hold_idx_q, hold_idx_d;
  logic            perr_q, perr_d;

  logic [IdxW-1:0] win_idx;
  logic [IdxW-1:0] head_idx;
  logic            fifo_full, fifo_empty;
  logic            handshake, rsp_pop;

  // Winner selection. The loop walks from the farthest offset back to the pointer,
  // so the last hit is the first requester at or after the pointer. A stalled,
  // still-requesting host overrides the scan so the payload cannot switch under it.
  always_comb begin
    int idx;
    idx     = 0;
    win_idx = ptr_q;
    for (int k = NrHosts - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= int'(NrHosts)) idx = idx - int'(NrHosts);
      if (host_req_i[IdxW'(idx)]) win_idx = IdxW'(idx);
    end
    if (state_q == HOLD && host_req_i[hold_idx_q]) win_idx = hold_idx_q;
  end

  // The full flag comes from registered occupancy, so a pop in this cycle does not free a slot until the next cycle.
  assign dev_req_o   = (|host_req_i) & ~fifo_full & ~rst_i;
  assign handshake   = dev_req_o & dev_gnt_i;
  assign dev_addr_o  = host_addr_i[win_idx];
  assign dev_we_o    = host_we_i[win_idx];
  assign dev_be_o    = host_be_i[win_idx];
  assign dev_wdata_o = host_wdata_i[win_idx];

  assign rsp_pop        = dev_rvalid_i & ~fifo_empty;
  assign host_rdata_o   = dev_rdata_i;
  assign host_err_o     = dev_err_i & dev_rvalid_i;
  assign protocol_err_o = perr_q;

  always_comb begin
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    if (handshake) host_gnt_o[win_idx]   = 1'b1;
    if (rsp_pop)   host_rvalid_o[head_idx] = 1'b1;
  end

  // A dropped request in HOLD is treated like IDLE. The scan above has already
  // picked a new winner, and that winner may be latched in turn if it stalls.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_idx_d = hold_idx_q;
    perr_d     = perr_q | (dev_rvalid_i & fifo_empty);
    if (handshake) begin
      state_d = IDLE;
      ptr_d   = (win_idx == IdxW'(NrHosts - 1)) ? '0 : win_idx + IdxW'(1);
    end else if (dev_req_o) begin
      state_d    = HOLD;
      hold_idx_d = win_idx;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_idx_q <= '0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_idx_q <= hold_idx_d;
      perr_q     <= perr_d;
    end
  end

  // Holds the granted host index of every outstanding transaction, in grant order.
  bus_rr_fifo #(
    .Width (IdxW),
    .Depth (MaxOutstanding)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (handshake),
    .pop_i   (rsp_pop),
    .wdat_i  (win_idx),
    .rdat_o  (head_idx),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Testbench for bus_rr_arbiter: a directed cycle table, then a randomized run checked against a reference model.
// Latency: every output is compared each cycle, away from the clock edge.
// Backpressure: dev_gnt_i is stalled, and responses are withheld, both in the table and at random.
module tb_bus_rr_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int M  = 2;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic [N-1:0]         host_req_i = '0;
  logic [N-1:0][AW-1:0] host_addr_i = '0;
  logic [N-1:0]         host_we_i = '0;
  logic [N-1:0][BW-1:0] host_be_i = '0;
  logic [N-1:0][DW-1:0] host_wdata_i = '0;
  logic [N-1:0]         host_gnt_o, host_rvalid_o;
  logic [DW-1:0]        host_rdata_o;
  logic                 host_err_o, dev_req_o, dev_we_o, protocol_err_o;
  logic [AW-1:0]        dev_addr_o;
  logic [BW-1:0]        dev_be_o;
  logic [DW-1:0]        dev_wdata_o;
  logic                 dev_gnt_i = 1'b0, dev_rvalid_i = 1'b0, dev_err_i = 1'b0;
  logic [DW-1:0]        dev_rdata_i = '0;

  bus_rr_arbiter #(.NrHosts(N), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(M)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .host_req_i(host_req_i), .host_addr_i(host_addr_i), .host_we_i(host_we_i),
    .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
    .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o),
    .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
    .dev_req_o(dev_req_o), .dev_addr_o(dev_addr_o), .dev_we_o(dev_we_o),
    .dev_be_o(dev_be_o), .dev_wdata_o(dev_wdata_o),
    .dev_gnt_i(dev_gnt_i), .dev_rvalid_i(dev_rvalid_i),
    .dev_rdata_i(dev_rdata_i), .dev_err_i(dev_err_i),
    .protocol_err_o(protocol_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // One table row is one clock cycle. A value of -1 in ehost means dev_addr_o is not checked.
  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic       gnt;
    logic       rv;
    logic       ereq;
    logic [1:0] egnt;
    logic [1:0] erv;
    logic       eperr;
    int         ehost;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic rst, input logic [1:0] req, input logic gnt, input logic rv,
                     input logic ereq, input logic [1:0] egnt, input logic [1:0] erv,
                     input logic eperr, input int ehost);
    vec_t v;
    v.rst = rst; v.req = req; v.gnt = gnt; v.rv = rv;
    v.ereq = ereq; v.egnt = egnt; v.erv = erv; v.eperr = eperr; v.ehost = ehost;
    tbl.push_back(v);
  endtask

  // Reference model: a scan pointer, the host being held (-1 when none), and a queue of outstanding host indices.
  int m_ptr = 0;
  int m_hold = -1;
  int m_q[$];
  bit m_perr = 1'b0;

  task automatic model_reset();
    m_ptr = 0; m_hold = -1; m_q.delete(); m_perr = 1'b0;
  endtask

  task automatic rand_step();
    int   w;
    bit   ereq;
    logic [N-1:0] egnt, erv;
    @(negedge clk_i);
    rst_i        = ($urandom_range(0, 63) == 0);
    host_req_i   = N'($urandom_range(0, (1 << N) - 1));
    dev_gnt_i    = $urandom_range(0, 1) == 1;
    dev_rvalid_i = (m_q.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 31) == 0);
    dev_rdata_i  = $urandom;
    dev_err_i    = $urandom_range(0, 1) == 1;
    for (int h = 0; h < N; h++) begin
      host_addr_i[h]  = $urandom;
      host_we_i[h]    = $urandom_range(0, 1) == 1;
      host_be_i[h]    = BW'($urandom);
      host_wdata_i[h] = $urandom;
    end
    #1;
    w = -1;
    if (m_hold >= 0 && host_req_i[m_hold]) w = m_hold;
    else
      for (int k = 0; k < N; k++)
        if (w < 0 && host_req_i[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    ereq = !rst_i && (w >= 0) && (m_q.size() < M);
    egnt = (ereq && dev_gnt_i) ? N'(1 << w) : '0;
    erv  = (dev_rvalid_i && m_q.size() > 0) ? N'(1 << m_q[0]) : '0;
    chk("rnd_dev_req", 64'(dev_req_o), 64'(ereq));
    chk("rnd_gnt", 64'(host_gnt_o), 64'(egnt));
    chk("rnd_rvalid", 64'(host_rvalid_o), 64'(erv));
    chk("rnd_perr", 64'(protocol_err_o), 64'(m_perr));
    chk("rnd_err", 64'(host_err_o), 64'(dev_err_i & dev_rvalid_i));
    if (erv != '0) chk("rnd_rdata", 64'(host_rdata_o), 64'(dev_rdata_i));
    if (ereq) begin
      chk("rnd_addr", 64'(dev_addr_o), 64'(host_addr_i[w]));
      chk("rnd_wpay", {27'b0, dev_we_o, dev_be_o, dev_wdata_o},
          {27'b0, host_we_i[w], host_be_i[w], host_wdata_i[w]});
    end
    if (rst_i) model_reset();
    else begin
      if (dev_rvalid_i) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_perr = 1'b1;
      end
      if (ereq && dev_gnt_i) begin
        m_q.push_back(w);
        m_ptr  = (w + 1) % N;
        m_hold = -1;
      end else m_hold = ereq ? w : -1;
    end
  endtask

  initial begin
    // Initial reset; the state is unknown before it, so nothing is compared.
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);

    //   rst  req    gnt rv  ereq egnt   erv    perr host
    // Both hosts requesting, always granted, response one cycle later: grants alternate.
    add(0, 2'b11, 1, 0, 1, 2'b01, 2'b00, 0, 0);
    add(0, 2'b11, 1, 1, 1, 2'b10, 2'b01, 0, 1);
    add(0, 2'b11, 1, 1, 1, 2'b01, 2'b10, 0, 0);
    add(0, 2'b11, 1, 1, 1, 2'b10, 2'b01, 0, 1);
    add(0, 2'b00, 1, 1, 0, 2'b00, 2'b10, 0, -1);
    // H1 stalls for 3 cycles and H0 joins; the payload stays on H1, then H0 is granted.
    add(0, 2'b10, 0, 0, 1, 2'b00, 2'b00, 0, 1);
    add(0, 2'b11, 0, 0, 1, 2'b00, 2'b00, 0, 1);
    add(0, 2'b11, 0, 0, 1, 2'b00, 2'b00, 0, 1);
    add(0, 2'b11, 1, 0, 1, 2'b10, 2'b00, 0, 1);
    add(0, 2'b11, 1, 0, 1, 2'b01, 2'b00, 0, 0);
    // FIFO full: no request; a pop does not unblock the same cycle, only the next one.
    add(0, 2'b11, 1, 0, 0, 2'b00, 2'b00, 0, -1);
    add(0, 2'b11, 1, 1, 0, 2'b00, 2'b10, 0, -1);
    add(0, 2'b11, 1, 0, 1, 2'b10, 2'b00, 0, 1);
    // One-cycle reset with 2 outstanding: requests are forced off, then H0 wins from pointer 0.
    add(1, 2'b11, 1, 0, 0, 2'b00, 2'b00, 0, -1);
    add(0, 2'b11, 1, 0, 1, 2'b01, 2'b00, 0, 0);
    add(0, 2'b00, 0, 1, 0, 2'b00, 2'b01, 0, -1);
    // Response with nothing outstanding: dropped, then sticky error until reset.
    add(0, 2'b00, 0, 1, 0, 2'b00, 2'b00, 0, -1);
    add(0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 1, -1);
    add(0, 2'b01, 1, 0, 1, 2'b01, 2'b00, 1, 0);
    add(1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 1, -1);
    add(0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, -1);
    // Held H0 drops its request: H1 is arbitrated the same cycle, then held and granted.
    add(0, 2'b01, 0, 0, 1, 2'b00, 2'b00, 0, 0);
    add(0, 2'b10, 0, 0, 1, 2'b00, 2'b00, 0, 1);
    add(0, 2'b11, 1, 0, 1, 2'b10, 2'b00, 0, 1);
    add(0, 2'b00, 0, 1, 0, 2'b00, 2'b10, 0, -1);

    host_addr_i[0] = 32'h0000_1000;
    host_addr_i[1] = 32'h0000_2000;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk_i);
      rst_i        = tbl[i].rst;
      host_req_i   = tbl[i].req;
      dev_gnt_i    = tbl[i].gnt;
      dev_rvalid_i = tbl[i].rv;
      #1;
      chk($sformatf("v%0d_dev_req", i), 64'(dev_req_o), 64'(tbl[i].ereq));
      chk($sformatf("v%0d_gnt", i), 64'(host_gnt_o), 64'(tbl[i].egnt));
      chk($sformatf("v%0d_rvalid", i), 64'(host_rvalid_o), 64'(tbl[i].erv));
      chk($sformatf("v%0d_perr", i), 64'(protocol_err_o), 64'(tbl[i].eperr));
      if (tbl[i].ehost >= 0)
        chk($sformatf("v%0d_addr", i), 64'(dev_addr_o),
            (tbl[i].ehost == 0) ? 64'h1000 : 64'h2000);
    end

    // Randomized phase starts from a fresh reset.
    @(negedge clk_i);
    rst_i = 1'b1; host_req_i = '0; dev_rvalid_i = 1'b0;
    @(negedge clk_i);
    model_reset();
    for (int c = 0; c < 3000; c++) rand_step();

    @(negedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bus_rr_arbiter.md
BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 SHALL have parameter NrHosts, default 2, number of requesting hosts (2..8).
REQ-002 SHALL have parameter AddrWidth, default 32, address width.
REQ-003 SHALL have parameter DataWidth, default 32, data width; byte-enable width is DataWidth/8.
REQ-004 SHALL have parameter MaxOutstanding, default 2, depth of the response-routing FIFO (1..8).
REQ-005 SHALL have one clock and a synchronous, active-high reset.
REQ-006 Ports (name, direction, width, meaning):
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous active-high reset.
- host_req_i  in  NrHosts  per-host request.
- host_addr_i, host_we_i, host_be_i, host_wdata_i  in  NrHosts x (AddrWidth, 1, DataWidth/8, DataWidth)  per-host request payload.
- host_gnt_o  out  NrHosts  per-host grant.
- host_rvalid_o  out  NrHosts  per-host response valid.
- host_rdata_o  out  DataWidth  response data, shared by all hosts.
- host_err_o  out  1  response error, shared by all hosts.
- dev_req_o  out  1  device request.
- dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o  out  (AddrWidth, 1, DataWidth/8, DataWidth)  device request payload.
- dev_gnt_i  in  1  device grant.
- dev_rvalid_i  in  1  device response valid.
- dev_rdata_i  in  DataWidth  device response data.
- dev_err_i  in  1  device response error.
- protocol_err_o  out  1  sticky flag: unexpected response received.

Function
REQ-007 SHALL select the winner as the first requesting host at or after the priority pointer, scanning upward with wrap-around modulo NrHosts.
REQ-008 dev_req_o SHALL be 1 iff any host_req_i is 1 and the FIFO is not full; dev_addr/we/be/wdata SHALL be the winner's payload.
REQ-009 host_gnt_o[w] SHALL equal dev_req_o & dev_gnt_i for the winner w only; all other grant bits SHALL be 0 (combinational, zero added latency).
REQ-010 Handshake: dev_req_o & dev_gnt_i in a cycle. On a handshake the pointer SHALL become (w+1) mod NrHosts at the next edge.
REQ-011 FSM IDLE/HOLD:
- IDLE -> HOLD when dev_req_o=1 and dev_gnt_i=0; the current winner index SHALL be latched.
- In HOLD the latched host SHALL remain the winner regardless of other requests (no switching while a request is stalled).
- HOLD -> IDLE on handshake.
- If the latched host drops its request in HOLD, HOLD -> IDLE and arbitration resumes the same cycle.
REQ-012 Each handshake SHALL push the winner index into the FIFO; each dev_rvalid_i SHALL pop it.
REQ-013 A simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-014 When the FIFO is full, dev_req_o SHALL be 0 and no grants SHALL be issued. A pop in the same cycle does NOT unblock that cycle (registered full flag).
REQ-015 On dev_rvalid_i with FIFO non-empty:
- host_rvalid_o[head]=1, all other bits 0, same cycle.
- host_rdata_o=dev_rdata_i; host_err_o=dev_err_i & dev_rvalid_i.
REQ-016 On dev_rvalid_i with FIFO empty: all host_rvalid_o SHALL be 0, the response SHALL be dropped, and protocol_err_o SHALL set and hold until reset.
REQ-017 Response order SHALL equal grant order (in-order device assumed).
REQ-018 Pointer, FIFO indices and occupancy SHALL wrap modulo their size; occupancy width is clog2(MaxOutstanding+1).

Reset
REQ-019 While rst_i=1 at an edge, the next state SHALL be: pointer 0, FSM IDLE, FIFO empty, protocol_err_o 0.
REQ-020 While rst_i=1, dev_req_o and all host_gnt_o SHALL be forced to 0.
REQ-021 Reset asserted mid-transaction SHALL discard all outstanding entries. Responses arriving after reset with the FIFO empty follow REQ-016; the device is reset concurrently by the system.

Verification
REQ-022 Both hosts request continuously, dev_gnt_i=1, device rvalid 1 cycle later -> grants alternate H0,H1,H0,H1; each rvalid is routed to the matching host; protocol_err_o=0.
REQ-023 H1 requests with dev_gnt_i=0 for 3 cycles while H0 asserts in cycle 2 -> dev_addr_o stays at H1's address for 3 cycles; H1 is granted in cycle 4; H0 is granted next.
REQ-024 MaxOutstanding=2, dev_gnt_i=1, rvalid withheld -> exactly 2 grants, then dev_req_o=0; one rvalid -> dev_req_o=1 the following cycle.
REQ-025 Single rvalid pulse with no request ever granted -> no host_rvalid_o bit set; protocol_err_o=1 from the next cycle until rst_i.
REQ-026 rst_i pulsed for 1 cycle with 2 outstanding -> FIFO empty and pointer 0 afterwards; the first post-reset grant goes to H0 when both request.
